// File: rtl/io_clk_meas_pkg.sv
// io_clk_meas shared definitions: register offsets, status bits,
// measurement state and the Gray decoder used at the domain crossing.
package io_clk_meas_pkg;

  localparam logic [15:0] CRegResult = 16'd0;
  localparam logic [15:0] CRegMinMax = 16'd1;

  localparam int CBitValid   = 31;
  localparam int CBitStopped = 30;

  typedef enum logic {
    SInit,
    SRun
  } state_e;

  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/clk_meas_gray_cnt.sv
// Measured-clock edge counter with a registered Gray output; the only
// logic clocked by AClkM, so the crossing boundary lives here.
module clk_meas_gray_cnt #(
  parameter int CCntW = 16
) (
  input  logic             AClkM,
  input  logic             AResetMN,
  output logic [CCntW-1:0] FGrayM
);

  logic [CCntW-1:0] cnt_q, cnt_d;
  logic [CCntW-1:0] gray_q, gray_d;

  always_comb begin
    cnt_d  = cnt_q + CCntW'(1);
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge AClkM or negedge AResetMN) begin
    if (!AResetMN) begin
      cnt_q  <= '0;
      gray_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  assign FGrayM = gray_q;

endmodule

// File: rtl/io_clk_meas.sv
// IO-mapped clock frequency meter: counts AClkM edges per AClkX gate window.
// Optional min/max tracking at offset 1 with IO_CLK_MEAS_MINMAX_EN.
module io_clk_meas
  import io_clk_meas_pkg::*;
#(
  parameter logic [15:0] CAddrBase    = 16'h0000,
  parameter int          CCntW        = 16,
  parameter logic [15:0] CGateDefault = 16'h03E7
) (
  input  logic        AClkX,
  input  logic        AResetXN,
  input  logic        AClkXEn,
  input  logic        AClkM,
  input  logic        AResetMN,
  input  logic [15:0] AIoAddr,
  input  logic [63:0] AIoMosi,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic [63:0] AIoMiso,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr
);

  logic [CCntW-1:0] gray_m;

  clk_meas_gray_cnt #(
    .CCntW(CCntW)
  ) u_gray_cnt (
    .AClkM   (AClkM),
    .AResetMN(AResetMN),
    .FGrayM  (gray_m)
  );

  logic [CCntW-1:0] sync1_q, sync1_d;
  logic [CCntW-1:0] sync2_q, sync2_d;
  logic [CCntW-1:0] cnt_x_q, cnt_x_d;
  logic [CCntW-1:0] prev_q, prev_d;
  logic [CCntW-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             stopped_q, stopped_d;
  logic [15:0]      gate_q, gate_d;
  logic [15:0]      gate_len_q, gate_len_d;
  state_e           state_q, state_d;
  logic [CCntW-1:0] delta;

  logic access, hit_res, hit_mm;
  logic legal_res, legal_mm;
  logic rd_res, wr_res, rd_mm;
  logic [31:0] status;
  logic [31:0] mm_word;

`ifdef IO_CLK_MEAS_MINMAX_EN
  logic [CCntW-1:0] min_q, min_d;
  logic [CCntW-1:0] max_q, max_d;
  logic             wr_mm;
`endif

  logic unused_mosi;
  assign unused_mosi = ^AIoMosi[63:16];

  always_comb begin
    access    = (AIoWrSize != 4'd0) || (AIoRdSize != 4'd0);
    hit_res   = access && (AIoAddr == CAddrBase + CRegResult);
    legal_res = (AIoWrSize == 4'd0 || AIoWrSize == 4'd2) &&
                (AIoRdSize == 4'd0 || AIoRdSize == 4'd4);
    legal_mm  = (AIoRdSize == 4'd0 || AIoRdSize == 4'd4);
`ifdef IO_CLK_MEAS_MINMAX_EN
    hit_mm    = access && (AIoAddr == CAddrBase + CRegMinMax);
    wr_mm     = hit_mm && legal_mm && (AIoWrSize != 4'd0);
`else
    hit_mm    = 1'b0;
`endif
    rd_res     = hit_res && legal_res && (AIoRdSize != 4'd0);
    wr_res     = hit_res && legal_res && (AIoWrSize != 4'd0);
    rd_mm      = hit_mm && legal_mm && (AIoRdSize != 4'd0);
    AIoAddrAck = (hit_res && legal_res) || (hit_mm && legal_mm);
    AIoAddrErr = (hit_res && !legal_res) || (hit_mm && !legal_mm);
  end

  always_comb begin
    status              = '0;
    status[CBitValid]   = valid_q;
    status[CBitStopped] = stopped_q;
    status[15:0]        = 16'(result_q);
`ifdef IO_CLK_MEAS_MINMAX_EN
    mm_word = {16'(max_q), 16'(min_q)};
`else
    mm_word = '0;
`endif
    unique case (1'b1)
      rd_res:  AIoMiso = {32'h0, status};
      rd_mm:   AIoMiso = {32'h0, mm_word};
      default: AIoMiso = '0;
    endcase
  end

  always_comb begin
    sync1_d    = sync1_q;
    sync2_d    = sync2_q;
    cnt_x_d    = cnt_x_q;
    prev_d     = prev_q;
    result_d   = result_q;
    valid_d    = valid_q;
    stopped_d  = stopped_q;
    gate_d     = gate_q;
    gate_len_d = gate_len_q;
    state_d    = state_q;
    delta      = cnt_x_q - prev_q;
`ifdef IO_CLK_MEAS_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
`endif
    if (AClkXEn) begin
      sync1_d = gray_m;
      sync2_d = sync1_q;
      cnt_x_d = CCntW'(gray2bin(16'(sync2_q)));
      if (rd_res) begin
        valid_d   = 1'b0;
        stopped_d = 1'b0;
      end
      if (gate_q == 16'd0) begin
        gate_d = gate_len_q;
        prev_d = cnt_x_q;
        if (state_q == SInit) begin
          state_d = SRun;
        end else begin
          result_d = delta;
          valid_d  = 1'b1;
          if (delta == '0) stopped_d = 1'b1;
`ifdef IO_CLK_MEAS_MINMAX_EN
          if (delta < min_q) min_d = delta;
          if (delta > max_q) max_d = delta;
`endif
        end
      end else begin
        gate_d = gate_q - 16'd1;
      end
`ifdef IO_CLK_MEAS_MINMAX_EN
      if (wr_mm) begin
        min_d = '1;
        max_d = '0;
      end
`endif
      // A gate write overrides any capture landing on the same edge.
      if (wr_res) begin
        gate_len_d = AIoMosi[15:0];
        gate_d     = AIoMosi[15:0];
        prev_d     = prev_q;
        result_d   = '0;
        valid_d    = 1'b0;
        stopped_d  = 1'b0;
        state_d    = SInit;
`ifdef IO_CLK_MEAS_MINMAX_EN
        min_d      = '1;
        max_d      = '0;
`endif
      end
    end
  end

  always_ff @(posedge AClkX or negedge AResetXN) begin
    if (!AResetXN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_x_q    <= '0;
      prev_q     <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      stopped_q  <= 1'b0;
      gate_q     <= CGateDefault;
      gate_len_q <= CGateDefault;
      state_q    <= SInit;
`ifdef IO_CLK_MEAS_MINMAX_EN
      min_q      <= '1;
      max_q      <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_x_q    <= cnt_x_d;
      prev_q     <= prev_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      stopped_q  <= stopped_d;
      gate_q     <= gate_d;
      gate_len_q <= gate_len_d;
      state_q    <= state_d;
`ifdef IO_CLK_MEAS_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

endmodule
